// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start-bit detect, N-bit MSB-first shift, stop-bit check,
// and a registered valid/ready output port with framing-error and overrun pulses.
module sipo_frame_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         serial_in,
    input  logic         data_ready,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [N-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
    logic           busy_q, busy_d;
    logic           out_free_s;

    // Next-state, shifter, handshake and pulse logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        // A consumed word drops valid unless a new frame commits below
        valid_d    = valid_q & ~data_ready;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        out_free_s = ~valid_q | data_ready;

        case (state_q)
            ST_IDLE: begin
                if (bit_en && !serial_in) begin
                    state_d = ST_DATA;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bit_en) begin
                    shift_d = {shift_q[N-2:0], serial_in};
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_en) begin
                    state_d = ST_IDLE;
                    if (!serial_in) begin
                        ferr_d = 1'b1;
                    end else if (out_free_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            shift_q <= {N{1'b0}};
            data_q  <= {N{1'b0}};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed and random frames checked every cycle
// against a frame-level reference model.
module tb_sipo_frame_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         bit_en;
    logic         serial_in;
    logic         data_ready;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [N-1:0] exp_data;
    logic         exp_valid;
    logic         exp_ferr;
    logic         exp_ovr;
    logic         exp_busy;
    logic [N-1:0] cur_frame;

    sipo_frame_ctrl #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"},   {24'd0, data_out}, {24'd0, exp_data});
        check({tag, ".data_valid"}, {31'd0, data_valid}, {31'd0, exp_valid});
        check({tag, ".frame_err"},  {31'd0, frame_err}, {31'd0, exp_ferr});
        check({tag, ".overrun"},    {31'd0, overrun}, {31'd0, exp_ovr});
        check({tag, ".busy"},       {31'd0, busy}, {31'd0, exp_busy});
    endtask

    // ev: 0 = ordinary cycle, 1 = start bit sampled, 2 = stop bit sampled
    task automatic clk_cycle(input logic en, input logic sin, input logic rdy, input int ev,
                             input string tag);
        logic commit;
        logic old_valid;
        bit_en     = en;
        serial_in  = sin;
        data_ready = rdy;
        @(posedge clk);
        old_valid = exp_valid;
        commit    = (ev == 2) && sin && (!old_valid || rdy);
        exp_ferr  = (ev == 2) && !sin;
        exp_ovr   = (ev == 2) && sin && old_valid && !rdy;
        if (commit) begin
            exp_data  = cur_frame;
            exp_valid = 1'b1;
        end else if (old_valid && rdy) begin
            exp_valid = 1'b0;
        end
        if (ev == 1) exp_busy = 1'b1;
        if (ev == 2) exp_busy = 1'b0;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) clk_cycle(1'b1, 1'b1, rdy, 0, "idle");
    endtask

    // rdy_mode: 0/1 = constant data_ready off the stop edge, 2 = random per cycle
    task automatic send_frame(input logic [N-1:0] data, input logic stop_bit,
                              input int period, input int rdy_mode, input logic rdy_stop,
                              input string tag);
        logic b;
        logic r;
        int   ev;
        cur_frame = data;
        for (int idx = 0; idx <= N + 1; idx++) begin
            if (idx == 0)      b = 1'b0;
            else if (idx <= N) b = data[N-idx];
            else               b = stop_bit;
            for (int p = 0; p < period; p++) begin
                if (p != 0)             ev = 0;
                else if (idx == 0)      ev = 1;
                else if (idx == N + 1)  ev = 2;
                else                    ev = 0;
                if (idx == N + 1 && p == 0) r = rdy_stop;
                else if (rdy_mode == 2)     r = 1'($urandom_range(1, 0));
                else                        r = 1'(rdy_mode);
                clk_cycle((p == 0), b, r, ev, tag);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        bit_en     = 1'b0;
        serial_in  = 1'b1;
        data_ready = 1'b0;
        exp_data   = '0;
        exp_valid  = 1'b0;
        exp_ferr   = 1'b0;
        exp_ovr    = 1'b0;
        exp_busy   = 1'b0;
        cur_frame  = '0;

        @(negedge clk);
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        idle(2, 1'b0);

        // Basic frame, consumer stalled, then a single ready cycle
        send_frame(8'hA5, 1'b1, 1, 0, 1'b0, "a5");
        check("a5.final", {24'd0, data_out}, 32'h0000_00A5);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Bad stop bit, then a good frame
        send_frame(8'hA5, 1'b0, 1, 0, 1'b0, "ferr");
        idle(1, 1'b0);
        send_frame(8'h3C, 1'b1, 1, 0, 1'b0, "3c");
        idle(1, 1'b1);

        // Overrun: second frame lands on a full output
        send_frame(8'hA5, 1'b1, 1, 0, 1'b0, "ovr1");
        send_frame(8'h5A, 1'b1, 1, 0, 1'b0, "ovr2");
        check("ovr.keep", {24'd0, data_out}, 32'h0000_00A5);
        idle(2, 1'b0);
        idle(1, 1'b1);

        // Back-to-back, consumer reads on the second commit edge
        send_frame(8'h81, 1'b1, 1, 0, 1'b0, "b2b1");
        send_frame(8'h7E, 1'b1, 1, 0, 1'b1, "b2b2");
        check("b2b.data", {24'd0, data_out}, 32'h0000_007E);
        idle(1, 1'b1);

        // Strobe once every 4 clocks
        send_frame(8'hC3, 1'b1, 4, 0, 1'b0, "slow");
        check("slow.data", {24'd0, data_out}, 32'h0000_00C3);
        idle(1, 1'b1);

        // Reset in the middle of a frame
        send_frame(8'h11, 1'b1, 1, 0, 1'b0, "pre");
        cur_frame = 8'hFF;
        clk_cycle(1'b1, 1'b0, 1'b0, 1, "part");
        for (int i = 0; i < 4; i++) clk_cycle(1'b1, 1'b1, 1'b0, 0, "part");
        #1;
        reset = 1'b0;
        #1;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_busy  = 1'b0;
        check_all("midreset");
        @(negedge clk);
        reset = 1'b1;
        idle(1, 1'b0);
        send_frame(8'hF0, 1'b1, 1, 0, 1'b0, "f0");
        idle(1, 1'b1);

        // Random frames, stop bits, strobe rates and consumer behaviour
        for (int k = 0; k < 40; k++) begin
            send_frame(N'($urandom), ($urandom_range(7, 0) != 0), $urandom_range(3, 1),
                       2, 1'($urandom_range(1, 0)), "rand");
            if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 1), 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
